present_round_engine: RTL and testbench
=======================================

// Module: present_round_engine
// PURPOSE
// - Iterative PRESENT block-cipher encryption datapath. Consumes a 64-bit plaintext and a cipher key and emits a 64-bit ciphertext.
// - One round per clock. Round keys are derived on the fly by the same schedule the key-expansion stage defines.
// - Sits directly downstream of key setup: takes the original key and produces round keys K1..K(ROUNDS+1) internally.
// - Replaces the unrolled per-round key array with one key register and one state register.
// PARAMETERS
// - ROUNDS   31   S/P rounds before the final whitening. Valid range 1..31; values below 31 are for reduced-round debug only.
// - KEY_W    80   Key width. Forced to 128 when PRESENT_KEY128_EN is defined.
// PORTS
// - clk        in   1      Single clock. All state updates on the rising edge.
// - rst_n      in   1      Reset: synchronous, active-low.
// - in_valid   in   1      Plaintext and key present on in_data and in_key.
// - in_ready   out  1      Engine idle; a block is accepted when in_valid && in_ready.
// - in_data    in   64     Plaintext.
// - in_key     in   KEY_W  Cipher key. Bit KEY_W-1 is k79 (or k127).
// - out_valid  out  1      Ciphertext valid on out_data. Held until accepted.
// - out_ready  in   1      Consumer accepts when out_valid && out_ready.
// - out_data   out  64     Ciphertext.
// - busy       out  1      High in the RUN and FINAL states.
// BEHAVIOUR
// - Reset values: in_ready=0 during rst_n=0 and 1 on the first cycle after. out_valid=0, out_data=0, busy=0. Internal state, key and rnd are all 0.
// - FSM has four states: IDLE, RUN, FINAL, DONE.
//   - IDLE: in_ready=1. On accept: state<=in_data, key<=in_key, rnd<=1, go to RUN. Inputs are sampled only at that edge.
//   - RUN: each cycle, state <= P(S(state ^ key[KEY_W-1 -: 64])) and key <= ks(key, rnd).
//     - If rnd==ROUNDS, go to FINAL; otherwise rnd<=rnd+1.
//   - FINAL: out_data <= state ^ key[KEY_W-1 -: 64] (this is K(ROUNDS+1)); out_valid<=1; go to DONE.
//   - DONE: hold out_data and out_valid. On out_ready, out_valid<=0 and go to IDLE.
//     - in_ready rises on the following cycle, so there is no same-cycle re-accept.
// - Latency: accept at edge N gives out_valid high after edge N+ROUNDS+1, i.e. 32 cycles at default ROUNDS.
//   - Throughput is one block per ROUNDS+3 cycles with out_ready tied high.
// - S: PRESENT 4-bit S-box applied nibble-wise: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
// - P: bit i moves to (16*i) mod 63 for i<63; bit 63 stays fixed.
// - ks for 80-bit keys, in order:
//   - rotate the key left by 61;
//   - k[79:76] <= S(k[79:76]);
//   - k[19:15] ^= rnd[4:0].
// - rnd is a 5-bit counter and never wraps: the maximum is 31, reached in the last RUN cycle.
// - in_valid while busy is ignored. The source must hold it; in_ready=0 applies backpressure.
// - out_ready while out_valid=0 has no effect.
// - rst_n low in any state returns the engine to IDLE at that edge. An in-flight block is discarded and out_data is cleared to 0.
// - No combinational path from any input to any output.
// CONFIGURATION
// - PRESENT_KEY128_EN defined:
//   - KEY_W=128;
//   - ks = rotate left by 61; k[127:124] <= S(k[127:124]); k[123:120] <= S(k[123:120]); k[66:62] ^= rnd[4:0].
// - PRESENT_KEY128_EN undefined: 80-bit key path only, and no 128-bit logic is synthesised.
// - Latency and handshake are identical in both builds.
// TESTING
// - 80-bit build, key=0, pt=0 -> ct=5579C1387B228445; out_valid rises exactly 32 cycles after the accept edge.
// - 80-bit build, key=FFFF_FFFF_FFFF_FFFF_FFFF:
//   - pt=0 -> E72C46C0F5945049;
//   - pt=FFFFFFFFFFFFFFFF -> 3333DCD3213210D2.
// - 80-bit build, key=0, pt=FFFFFFFFFFFFFFFF -> A112FFC72F68417B.
//   - Hold out_ready=0 for 10 cycles: out_valid and out_data stay stable, in_ready stays 0, a second in_valid is not accepted.
// - Back-to-back blocks, in_valid and out_ready both tied high: one accept every 34 cycles, ciphertexts in order, none dropped.
// - Reset mid-op: drop rst_n at round 15 -> next cycle out_valid=0, out_data=0, in_ready=1. A new block then encrypts correctly.
// - PRESENT_KEY128_EN build, key=0, pt=0 -> ct=96DB702A2E6900AF, with the same 32-cycle latency.

Source files
------------

// File: rtl/present_round_engine.sv
// Iterative PRESENT encryption engine: one S/P round per clock, with the round key derived on the fly.
// Define PRESENT_KEY128_EN for the 128-bit key schedule; the default build is the 80-bit key schedule.
module present_round_engine #(
   parameter int unsigned ROUNDS = 31,
`ifdef PRESENT_KEY128_EN
   localparam int unsigned KEY_W = 128
`else
   localparam int unsigned KEY_W = 80
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_data,
   input  logic [KEY_W-1:0] in_key,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_data,
   output logic             busy
);

   localparam int unsigned BLK_W = 64;
   localparam int unsigned RND_W = 5;
   // S-box entry x lives in nibble x: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2
   localparam logic [63:0] SBOX_TBL = 64'h2174_8FE3_DA09_B65C;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINAL, S_DONE} fsm_e;

   fsm_e             fsm_q, fsm_d;
   logic [BLK_W-1:0] state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [RND_W-1:0] rnd_q, rnd_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [BLK_W-1:0] out_data_q, out_data_d;
   logic             busy_q, busy_d;
   logic [BLK_W-1:0] round_key;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      return SBOX_TBL[{x, 2'b00} +: 4];
   endfunction

   function automatic logic [BLK_W-1:0] sbox_layer(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox(x[4*i +: 4]);
      return r;
   endfunction

   function automatic logic [BLK_W-1:0] p_layer(input logic [BLK_W-1:0] x);
      logic [BLK_W-1:0] r;
      r = '0;
      for (int i = 0; i < 63; i++) r[(16*i) % 63] = x[i];
      r[63] = x[63];
      return r;
   endfunction

   // Rotate left by 61 is a rotate right by KEY_W-61
   function automatic logic [KEY_W-1:0] key_sched(input logic [KEY_W-1:0] k,
                                                  input logic [RND_W-1:0] rc);
      logic [KEY_W-1:0] r;
`ifdef PRESENT_KEY128_EN
      r            = {k[66:0], k[127:67]};
      r[127:124]   = sbox(r[127:124]);
      r[123:120]   = sbox(r[123:120]);
      r[66:62]     = r[66:62] ^ rc;
`else
      r            = {k[18:0], k[79:19]};
      r[79:76]     = sbox(r[79:76]);
      r[19:15]     = r[19:15] ^ rc;
`endif
      return r;
   endfunction

   assign round_key = key_q[KEY_W-1 -: BLK_W];

   // Next-state and datapath
   always_comb begin
      fsm_d       = fsm_q;
      state_d     = state_q;
      key_d       = key_q;
      rnd_d       = rnd_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      case (fsm_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               state_d = in_data;
               key_d   = in_key;
               rnd_d   = RND_W'(1);
               fsm_d   = S_RUN;
            end
         end
         S_RUN: begin
            state_d = p_layer(sbox_layer(state_q ^ round_key));
            key_d   = key_sched(key_q, rnd_q);
            if (rnd_q == RND_W'(ROUNDS)) fsm_d = S_FINAL;
            else                         rnd_d = rnd_q + RND_W'(1);
         end
         S_FINAL: begin
            out_data_d  = state_q ^ round_key;
            out_valid_d = 1'b1;
            fsm_d       = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               fsm_d       = S_IDLE;
            end
         end
         default: fsm_d = S_IDLE;
      endcase
      in_ready_d = (fsm_d == S_IDLE);
      busy_d     = (fsm_d == S_RUN) || (fsm_d == S_FINAL);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm_q       <= S_IDLE;
         state_q     <= '0;
         key_q       <= '0;
         rnd_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         state_q     <= state_d;
         key_q       <= key_d;
         rnd_q       <= rnd_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_present_round_engine.sv
// Directed bench for present_round_engine: expected ciphertexts are queued at accept and checked at output.
module tb_present_round_engine;

`ifdef PRESENT_KEY128_EN
   localparam int unsigned KW = 128;
`else
   localparam int unsigned KW = 80;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [63:0]   in_data;
   logic [KW-1:0] in_key;
   logic          out_valid;
   logic          out_ready;
   logic [63:0]   out_data;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [63:0] exp_q[$];

   present_round_engine dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         tick();
         lat++;
      end
      if (!out_valid) check("out_valid_timeout", 64'(out_valid), 64'd1);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
   endtask

   // One full transaction from an idle engine, with latency and handshake checks
   task automatic run_block(input string tag, input logic [KW-1:0] key,
                            input logic [63:0] pt, input logic [63:0] ct);
      int lat;
      in_key   = key;
      in_data  = pt;
      in_valid = 1'b1;
      exp_q.push_back(ct);
      tick();
      in_valid = 1'b0;
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
      wait_out(lat);
      check({tag, "_latency"}, 64'(lat), 64'd32);
      check({tag, "_ct"}, out_data, exp_q.pop_front());
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_out_valid_clr"}, 64'(out_valid), 64'd0);
      check({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      int lat;
      int acc;
      int prev_acc;
      logic [KW-1:0] b2b_key[3];
      logic [63:0]   b2b_pt[3];
      logic [63:0]   b2b_ct[3];

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      in_key    = '0;
      tick();
      tick();
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

`ifdef PRESENT_KEY128_EN
      run_block("k128_zero", '0, 64'h0, 64'h96DB_702A_2E69_00AF);
`else
      run_block("k0_pt0", '0, 64'h0, 64'h5579_C138_7B22_8445);
      run_block("k1_pt0", '1, 64'h0, 64'hE72C_46C0_F594_5049);
      run_block("k1_pt1", '1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3333_DCD3_2132_10D2);

      // Output stall: result held, no second accept
      in_key   = '0;
      in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
      in_valid = 1'b1;
      exp_q.push_back(64'hA112_FFC7_2F68_417B);
      tick();
      in_valid = 1'b0;
      wait_out(lat);
      in_valid = 1'b1;
      in_data  = 64'h0123_4567_89AB_CDEF;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("hold_out_valid", 64'(out_valid), 64'd1);
         check("hold_out_data", out_data, exp_q[0]);
         check("hold_in_ready", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      check("hold_ct", out_data, exp_q.pop_front());
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("hold_out_valid_clr", 64'(out_valid), 64'd0);
      tick();
      check("hold_no_accept", 64'(busy), 64'd0);

      // Back-to-back with in_valid and out_ready held high
      b2b_key[0] = '0; b2b_pt[0] = 64'h0;                   b2b_ct[0] = 64'h5579_C138_7B22_8445;
      b2b_key[1] = '1; b2b_pt[1] = 64'h0;                   b2b_ct[1] = 64'hE72C_46C0_F594_5049;
      b2b_key[2] = '1; b2b_pt[2] = 64'hFFFF_FFFF_FFFF_FFFF; b2b_ct[2] = 64'h3333_DCD3_2132_10D2;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      prev_acc  = 0;
      for (int b = 0; b < 3; b++) begin
         in_key  = b2b_key[b];
         in_data = b2b_pt[b];
         exp_q.push_back(b2b_ct[b]);
         wait_ready();
         acc = cyc;
         tick();
         if (b == 2) in_valid = 1'b0;
         if (b > 0) check("b2b_spacing", 64'(acc - prev_acc), 64'd34);
         prev_acc = acc;
         wait_out(lat);
         check("b2b_ct", out_data, exp_q.pop_front());
      end
      tick();
      out_ready = 1'b0;
      check("b2b_idle", 64'(in_ready), 64'd1);
      check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

      // Reset in the middle of a block
      in_key   = '1;
      in_data  = 64'h0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (14) tick();
      check("mid_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      tick();
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_out_data", out_data, 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      tick();
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      run_block("after_rst", '0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA112_FFC7_2F68_417B);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
